usb_cmd_master: RTL and testbench
=================================

USB_CMD_MASTER -- requirements
Module: usb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle ftdi_clk cycles allowed between response bytes.
REQ-002 The block SHALL have port ftdi_clk  in  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port cmd_valid  in  1  command request.
REQ-005 The block SHALL have port cmd_ready  out  1  block accepts a command this cycle.
REQ-006 The block SHALL have ports cmd_write  in  1  (1 = write, 0 = read), cmd_addr  in  6  register address, cmd_wdata  in  8  write data, and cmd_len  in  16  number of response bytes expected on a read.
REQ-007 The block SHALL have port tx_start  out  1  one-cycle byte-send strobe to the serial transmitter.
REQ-008 The block SHALL have ports tx_data  out  8  byte to send, and tx_busy  in  1  transmitter busy.
REQ-009 The block SHALL have ports rx_ready  in  1  one-cycle received-byte strobe, and rx_data  in  8  received byte.
REQ-010 The block SHALL have ports rsp_valid  out  1, rsp_data  out  8, and rsp_last  out  1  read-response byte stream.
REQ-011 The block SHALL have ports done  out  1  one-cycle command-complete pulse, and timeout_err  out  1  status of the last completed command.

Function
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1, and cmd_write, cmd_addr, cmd_wdata and cmd_len are latched that cycle.
REQ-013 The address byte SHALL be {1,1,cmd_addr} for a write and {1,0,cmd_addr} for a read.
REQ-014 The state machine SHALL have states IDLE, SEND_ADDR, WAIT_ADDR, SEND_DATA, WAIT_DATA, RECV, DONE.
REQ-015 In SEND_x, when tx_busy=0, the block SHALL pulse tx_start for exactly one cycle with tx_data valid and go to WAIT_x; while tx_busy=1 it SHALL stay in SEND_x.
REQ-016 WAIT_x SHALL ignore tx_busy on its first cycle and exit on the first later cycle with tx_busy=0.
REQ-017 Write transitions SHALL be IDLE->SEND_ADDR->WAIT_ADDR->SEND_DATA->WAIT_DATA->DONE, with tx_data=latched cmd_wdata in SEND_DATA.
REQ-018 Read transitions SHALL be IDLE->SEND_ADDR->WAIT_ADDR->RECV->DONE; when the latched cmd_len=0, WAIT_ADDR SHALL go directly to DONE and no rsp_valid SHALL occur.
REQ-019 In RECV, each rx_ready SHALL produce rsp_valid=1 for one cycle in the next cycle, with rsp_data=rx_data and the remaining count decremented.
REQ-020 rsp_last SHALL be 1 with the rsp_valid of the final (cmd_len-th) byte; the cycle after that byte the state SHALL be DONE.
REQ-021 The remaining counter SHALL be 16 bits and SHALL never wrap below 0.
REQ-022 rx_ready outside RECV, including during SEND/WAIT of a write, SHALL be discarded with no rsp_valid.
REQ-023 DONE SHALL pulse done for one cycle, update timeout_err, and return to IDLE the next cycle.
REQ-024 A new command SHALL not be accepted in the DONE cycle.
REQ-025 rsp_valid SHALL have no backpressure; the consumer must accept every byte.

Reset
REQ-026 While reset=1, the state SHALL be IDLE, cmd_ready=0, and tx_start, rsp_valid, rsp_last, done and timeout_err SHALL be 0; tx_data, rsp_data and the remaining counter SHALL be 0.
REQ-027 cmd_ready SHALL rise on the first clock edge after reset deasserts.
REQ-028 Reset mid-command SHALL abort the command with no done pulse; a byte already handed to the transmitter is not recalled.

Configuration
REQ-029 With macro USB_CMD_TIMEOUT_EN defined, a counter SHALL clear on entry to RECV and on every rx_ready, and count otherwise.
REQ-030 With USB_CMD_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL force DONE with timeout_err=1 and no rsp_last.
REQ-031 With USB_CMD_TIMEOUT_EN defined, a successful completion SHALL set timeout_err=0.
REQ-032 With USB_CMD_TIMEOUT_EN undefined, RECV SHALL wait indefinitely, timeout_err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-033 Write test: write addr 0x04, data 0x5A, tx_busy high 10 cycles after each start -> tx bytes 0xC4 then 0x5A, exactly one tx_start each, then one done pulse.
REQ-034 Single-byte read test: read addr 0x02, len 1, rx byte 0x21 -> tx byte 0x82, then rsp_valid with rsp_data 0x21 and rsp_last=1, then done with timeout_err=0.
REQ-035 Burst read test: read addr 0x03, len 392, incrementing rx bytes -> 392 rsp_valid in order, rsp_last only on the 392nd, then one done.
REQ-036 Zero-length and stray-byte test: read len 0 -> done right after WAIT_ADDR exits; rx_ready injected in IDLE or during a write -> no rsp_valid.
REQ-037 Timeout test (USB_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100): read len 4 with 2 bytes returned -> 2 rsp_valid, done with timeout_err=1, no rsp_last.
REQ-038 Reset-abort test: reset asserted in RECV after 1 of 3 bytes -> all outputs 0 immediately, no done; the next command completes normally.

Source files
------------

// File: rtl/usb_cmd_master.sv
// Command master for an FTDI-style serial link: sends an address byte (and data byte on writes),
// then streams read-response bytes. Optional receive timeout is enabled by defining USB_CMD_TIMEOUT_EN.
module usb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        ftdi_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [15:0] cmd_len,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, SEND_ADDR, WAIT_ADDR, SEND_DATA, WAIT_DATA, RECV, DONE
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic        cmd_ready_q;
  logic        write_q;
  logic [5:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [15:0] rem_q;
  logic        wait_first_q;
  logic        rsp_valid_q, rsp_last_q;
  logic [7:0]  rsp_data_q;
  logic        accept, rx_take, timeout_hit;

  assign accept  = cmd_valid && cmd_ready_q;
  assign rx_take = (state_q == RECV) && rx_ready;

`ifdef USB_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_err_q;

  // to_cnt_q holds the idle cycles already spent in RECV; this cycle would be the last allowed one
  assign timeout_hit = (state_q == RECV) && !rx_ready &&
                       (to_cnt_q >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if ((state_q != RECV) || rx_ready) to_cnt_q <= '0;
      else                               to_cnt_q <= to_cnt_q + 1'b1;
      if ((state_d == DONE) && (state_q != DONE)) timeout_err_q <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IDLE: if (accept) state_d = SEND_ADDR;
      SEND_ADDR: begin
        tx_data = {1'b1, write_q, addr_q};
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_ADDR;
        end
      end
      // The transmitter may not raise busy until the cycle after the strobe
      WAIT_ADDR: begin
        if (!wait_first_q && !tx_busy)
          state_d = write_q ? SEND_DATA : ((rem_q == 16'd0) ? DONE : RECV);
      end
      SEND_DATA: begin
        tx_data = wdata_q;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = WAIT_DATA;
        end
      end
      WAIT_DATA: if (!wait_first_q && !tx_busy) state_d = DONE;
      RECV: begin
        if (rx_take && (rem_q == 16'd1)) state_d = DONE;
        else if (timeout_hit)            state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ftdi_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= 6'd0;
      wdata_q      <= 8'h00;
      rem_q        <= 16'd0;
      wait_first_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= (state_d == IDLE);
      wait_first_q <= tx_start;
      rsp_valid_q  <= rx_take;
      rsp_last_q   <= rx_take && (rem_q == 16'd1);
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        rem_q   <= cmd_write ? 16'd0 : cmd_len;
      end
      if (rx_take) begin
        rsp_data_q <= rx_data;
        if (rem_q != 16'd0) rem_q <= rem_q - 16'd1;
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_usb_cmd_master.sv
// Randomized self-checking bench for usb_cmd_master: a per-command reference built from the
// command fields (expected tx bytes, response bytes, done/timeout status) is compared to a monitor.
`timescale 1ns/1ps
module tb_usb_cmd_master;
  logic        ftdi_clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [15:0] cmd_len;
  logic        tx_start, tx_busy, busy_resp, busy_pre;
  logic [7:0]  tx_data;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rsp_valid, rsp_last, done, timeout_err;
  logic [7:0]  rsp_data;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  tx_q[$];
  logic [8:0]  rsp_q[$];
  int          done_cnt;
  logic        done_err;
  int          busy_cycles;
  logic [7:0]  rx_bytes[$];

  assign tx_busy = busy_resp | busy_pre;
  always #5 ftdi_clk = ~ftdi_clk;

  usb_cmd_master #(.TIMEOUT_CYCLES(100)) dut (
    .ftdi_clk(ftdi_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_ready(rx_ready), .rx_data(rx_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: record everything the DUT emits, sampled away from the active edge
  always @(negedge ftdi_clk) begin
    if (tx_start) begin
      chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
      tx_q.push_back(tx_data);
    end
    if (rsp_valid) rsp_q.push_back({rsp_last, rsp_data});
    if (done) begin
      done_cnt++;
      done_err = timeout_err;
    end
  end

  // Transmitter model: busy for busy_cycles edges following each start strobe
  initial begin
    busy_resp = 1'b0;
    forever begin
      @(negedge ftdi_clk);
      if (tx_start && busy_cycles > 0) begin
        @(posedge ftdi_clk); #1 busy_resp = 1'b1;
        repeat (busy_cycles) @(posedge ftdi_clk);
        #1 busy_resp = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic clear_mon();
    tx_q.delete();
    rsp_q.delete();
    done_cnt = 0;
    done_err = 1'b0;
  endtask

  task automatic issue(input string tag, input bit wr, input logic [5:0] addr,
                       input logic [7:0] wd, input int len);
    int k;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_len = 16'(len);
    k = 0;
    do begin @(negedge ftdi_clk); k++; end while (!cmd_ready && k < 50);
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    @(posedge ftdi_clk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 6'($urandom);
    cmd_wdata = 8'($urandom); cmd_len = 16'($urandom);
  endtask

  // Return once the address byte has gone out and the transmitter is idle again: DUT is then in RECV
  task automatic wait_recv();
    int k;
    k = 0;
    while (tx_q.size() < 1 && k < 200) begin @(posedge ftdi_clk); #2; k++; end
    k = 0;
    while (tx_busy && k < 200) begin @(posedge ftdi_clk); #2; k++; end
    repeat (2) @(posedge ftdi_clk);
    #1;
  endtask

  task automatic send_rx(input int first, input int count);
    int g;
    for (int i = first; i < first + count; i++) begin
      rx_ready = 1'b1; rx_data = rx_bytes[i];
      @(posedge ftdi_clk); #1;
      rx_ready = 1'b0; rx_data = 8'($urandom);
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge ftdi_clk); #1; end
    end
  endtask

  // base >= 0 gives incrementing bytes from base, otherwise random bytes
  task automatic run_cmd(input string tag, input bit wr, input logic [5:0] addr, input logic [7:0] wd,
                         input int len, input int nsend, input int busy, input int pre, input int base);
    int k, exp_n;
    bit exp_to;
    clear_mon();
    busy_cycles = busy;
    rx_bytes.delete();
    for (int i = 0; i < nsend; i++) rx_bytes.push_back((base >= 0) ? 8'(base + i) : 8'($urandom));
    busy_pre = (pre > 0);
    issue(tag, wr, addr, wd, len);
    if (pre > 0) begin
      repeat (pre) @(posedge ftdi_clk);
      #1 busy_pre = 1'b0;
    end
    if (!wr && len > 0) begin
      wait_recv();
      send_rx(0, nsend);
    end
    k = 0;
    while (done_cnt == 0 && k < 400) begin @(posedge ftdi_clk); #2; k++; end
    repeat (4) @(posedge ftdi_clk);
    #1;
    exp_to = 1'b0;
`ifdef USB_CMD_TIMEOUT_EN
    exp_to = !wr && (nsend < len);
`endif
    exp_n = wr ? 0 : ((nsend < len) ? nsend : len);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_timeout_err"}, 32'(done_err), 32'(exp_to));
    chk({tag, "_tx_cnt"}, 32'(tx_q.size()), wr ? 32'd2 : 32'd1);
    if (tx_q.size() > 0) chk({tag, "_tx_addr"}, 32'(tx_q[0]), 32'({1'b1, wr, addr}));
    if (wr && tx_q.size() > 1) chk({tag, "_tx_wdata"}, 32'(tx_q[1]), 32'(wd));
    chk({tag, "_rsp_cnt"}, 32'(rsp_q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < rsp_q.size(); i++)
      chk({tag, "_rsp"}, 32'(rsp_q[i]), 32'({(i == len - 1), rx_bytes[i]}));
  endtask

  initial begin
    bit   wr;
    int   len;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'd0; cmd_wdata = 8'h00;
    cmd_len = 16'd0; rx_ready = 1'b0; rx_data = 8'h00; busy_pre = 1'b0; busy_cycles = 0;
    clear_mon();
    repeat (3) @(posedge ftdi_clk);
    @(negedge ftdi_clk);
    chk_reset_outputs("reset");
    reset = 1'b0;
    #1 chk("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge ftdi_clk); #1;
    chk("cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

    run_cmd("wr04", 1'b1, 6'h04, 8'h5A, 0, 0, 10, 0, -1);
    run_cmd("rd02", 1'b0, 6'h02, 8'h00, 1, 1, 10, 0, 8'h21);
    run_cmd("burst", 1'b0, 6'h03, 8'h00, 392, 392, 3, 0, 0);
    run_cmd("len0", 1'b0, 6'h15, 8'h00, 0, 0, 2, 0, -1);
    run_cmd("prebusy", 1'b1, 6'h3F, 8'hA7, 0, 0, 1, 6, -1);

    // Stray rx_ready in IDLE
    clear_mon();
    repeat (3) begin
      rx_ready = 1'b1; rx_data = 8'($urandom);
      @(posedge ftdi_clk); #1 rx_ready = 1'b0;
      @(posedge ftdi_clk); #1;
    end
    repeat (3) @(posedge ftdi_clk);
    #1 chk("stray_idle_rsp_cnt", 32'(rsp_q.size()), 32'd0);

    // Stray rx_ready throughout a write (run_cmd expects no responses)
    fork
      run_cmd("stray_wr", 1'b1, 6'h21, 8'h3C, 0, 0, 5, 0, -1);
      begin
        @(posedge ftdi_clk); #1;
        repeat (30) begin
          rx_ready = 1'($urandom); rx_data = 8'($urandom);
          @(posedge ftdi_clk); #1;
        end
        rx_ready = 1'b0;
      end
    join

`ifdef USB_CMD_TIMEOUT_EN
    run_cmd("timeout", 1'b0, 6'h09, 8'h00, 4, 2, 2, 0, -1);
    run_cmd("after_to", 1'b0, 6'h0A, 8'h00, 2, 2, 2, 0, -1);
`endif

    // Reset in RECV after 1 of 3 bytes
    clear_mon();
    busy_cycles = 2;
    rx_bytes.delete();
    rx_bytes.push_back(8'hA5);
    issue("abort", 1'b0, 6'h11, 8'h00, 3);
    wait_recv();
    send_rx(0, 1);
    repeat (2) begin @(posedge ftdi_clk); #1; end
    reset = 1'b1;
    #1 chk_reset_outputs("abort");
    chk("abort_rsp_cnt", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() > 0) chk("abort_rsp0", 32'(rsp_q[0]), 32'h0A5);
    repeat (3) @(posedge ftdi_clk);
    @(negedge ftdi_clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    reset = 1'b0;
    run_cmd("post_abort", 1'b0, 6'h11, 8'h00, 3, 3, 2, 0, -1);

    for (int t = 0; t < 12; t++) begin
      wr  = 1'($urandom);
      len = $urandom_range(0, 6);
      run_cmd($sformatf("rnd%0d", t), wr, 6'($urandom), 8'($urandom), wr ? 0 : len,
              wr ? 0 : len + $urandom_range(0, 1), $urandom_range(0, 5),
              $urandom_range(0, 1) * $urandom_range(1, 4), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
